// File: rtl/load_store_unit.sv
// Load/store unit: aligns byte lanes, drives a req/ack data-memory port, extends load data.
// Define LSU_MISALIGNED_EN to perform misaligned (and word-crossing) accesses in hardware.
module load_store_unit #(
    parameter int unsigned DWIDTH = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [2:0]        req_funct3,
    input  logic [DWIDTH-1:0] req_addr,
    input  logic [DWIDTH-1:0] req_wdata,
    output logic              rsp_valid,
    output logic [DWIDTH-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              mem_req,
    output logic              mem_we,
    output logic [DWIDTH-1:0] mem_addr,
    output logic [3:0]        mem_wstrb,
    output logic [DWIDTH-1:0] mem_wdata,
    input  logic              mem_ack,
    input  logic [DWIDTH-1:0] mem_rdata
);

    typedef enum logic [1:0] {StIdle, StAcc0, StAcc1, StResp} state_e;

    state_e      state_q, state_d;
    logic        req_ready_q, req_ready_d;
    logic        we_q, we_d;
    logic [2:0]  funct3_q, funct3_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] rdata0_q, rdata0_d;
    logic [31:0] rsp_rdata_q, rsp_rdata_d;
    logic        rsp_err_q, rsp_err_d;
    logic        cross_q, cross_d;

    logic        req_illegal, misal_err, req_cross;
    logic [2:0]  req_size;
    logic [3:0]  req_end;
    logic [4:0]  shamt;
    logic [7:0]  mask8, strb8;
    logic [63:0] wdata64;
    logic [31:0] ld_lo, ld_hi, ld_word, ld_ext;
    logic [31:0] word_addr;

    // Decode of the incoming request, only consumed when it is accepted in StIdle.
    always_comb begin
        req_illegal = req_we ? (req_funct3[2] || req_funct3[1:0] == 2'b11)
                             : (req_funct3[1:0] == 2'b11 || req_funct3[2:1] == 2'b11);
        case (req_funct3[1:0])
            2'b00:   req_size = 3'd1;
            2'b01:   req_size = 3'd2;
            default: req_size = 3'd4;
        endcase
        req_end   = {2'b00, req_addr[1:0]} + {1'b0, req_size};
        req_cross = req_end > 4'd4;
`ifdef LSU_MISALIGNED_EN
        misal_err = 1'b0;
`else
        case (req_funct3[1:0])
            2'b00:   misal_err = 1'b0;
            2'b01:   misal_err = req_addr[0];
            default: misal_err = |req_addr[1:0];
        endcase
`endif
    end

    // Lane alignment from the latched request.
    always_comb begin
        shamt = {addr_q[1:0], 3'b000};
        case (funct3_q[1:0])
            2'b00:   mask8 = 8'h01;
            2'b01:   mask8 = 8'h03;
            default: mask8 = 8'h0F;
        endcase
        strb8   = mask8 << addr_q[1:0];
        wdata64 = {32'h0, wdata_q} << shamt;

        // Single-word loads see a zero upper word; crossing loads pair with the first word.
        ld_lo   = (state_q == StAcc1) ? rdata0_q : mem_rdata;
        ld_hi   = (state_q == StAcc1) ? mem_rdata : 32'h0;
        ld_word = 32'({ld_hi, ld_lo} >> shamt);
        case (funct3_q)
            3'b000:  ld_ext = {{24{ld_word[7]}}, ld_word[7:0]};
            3'b001:  ld_ext = {{16{ld_word[15]}}, ld_word[15:0]};
            3'b100:  ld_ext = {24'h0, ld_word[7:0]};
            3'b101:  ld_ext = {16'h0, ld_word[15:0]};
            default: ld_ext = ld_word;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        we_d        = we_q;
        funct3_d    = funct3_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        rdata0_d    = rdata0_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;
        cross_d     = cross_q;

        case (state_q)
            StIdle: begin
                if (req_valid) begin
                    we_d        = req_we;
                    funct3_d    = req_funct3;
                    addr_d      = req_addr;
                    wdata_d     = req_wdata;
                    cross_d     = req_cross;
                    rsp_rdata_d = 32'h0;
                    if (req_illegal || misal_err) begin
                        rsp_err_d = 1'b1;
                        state_d   = StResp;
                    end else begin
                        rsp_err_d = 1'b0;
                        state_d   = StAcc0;
                    end
                end
            end
            StAcc0: begin
                if (mem_ack) begin
                    if (cross_q) begin
                        rdata0_d = mem_rdata;
                        state_d  = StAcc1;
                    end else begin
                        rsp_rdata_d = we_q ? 32'h0 : ld_ext;
                        state_d     = StResp;
                    end
                end
            end
            StAcc1: begin
                if (mem_ack) begin
                    rsp_rdata_d = we_q ? 32'h0 : ld_ext;
                    state_d     = StResp;
                end
            end
            default: begin
                rsp_rdata_d = 32'h0;
                rsp_err_d   = 1'b0;
                state_d     = StIdle;
            end
        endcase

        req_ready_d = (state_d == StIdle);
    end

    always_comb begin
        word_addr = {addr_q[31:2], 2'b00};
        mem_req   = (state_q == StAcc0) || (state_q == StAcc1);
        mem_we    = mem_req && we_q;
        mem_addr  = 32'h0;
        mem_wstrb = 4'h0;
        mem_wdata = 32'h0;
        if (state_q == StAcc0) begin
            mem_addr  = word_addr;
            mem_wstrb = we_q ? strb8[3:0] : 4'h0;
            mem_wdata = we_q ? wdata64[31:0] : 32'h0;
        end else if (state_q == StAcc1) begin
            mem_addr  = word_addr + 32'd4;
            mem_wstrb = we_q ? strb8[7:4] : 4'h0;
            mem_wdata = we_q ? wdata64[63:32] : 32'h0;
        end
        rsp_valid = (state_q == StResp);
        rsp_err   = rsp_err_q;
        rsp_rdata = rsp_rdata_q;
        req_ready = req_ready_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            req_ready_q <= 1'b0;
            we_q        <= 1'b0;
            funct3_q    <= 3'h0;
            addr_q      <= 32'h0;
            wdata_q     <= 32'h0;
            rdata0_q    <= 32'h0;
            rsp_rdata_q <= 32'h0;
            rsp_err_q   <= 1'b0;
            cross_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            req_ready_q <= req_ready_d;
            we_q        <= we_d;
            funct3_q    <= funct3_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            rdata0_q    <= rdata0_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
            cross_q     <= cross_d;
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit; follows LSU_MISALIGNED_EN to pick misaligned expectations.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_ready, req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr, req_wdata;
    logic        rsp_valid, rsp_err;
    logic [31:0] rsp_rdata;
    logic        mem_req, mem_we, mem_ack;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_wstrb;

    int n_vec = 0;
    int n_err = 0;

    load_store_unit #(.DWIDTH(32)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wstrb(mem_wstrb), .mem_wdata(mem_wdata),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout want completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    // Present a request for one cycle; returns at the negedge of cycle T+1.
    task automatic send(input logic we, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] wd);
        req_valid  = 1'b1;
        req_we     = we;
        req_funct3 = f3;
        req_addr   = a;
        req_wdata  = wd;
        tick();
        req_valid  = 1'b0;
    endtask

    // Acknowledge the current memory access with the given read word.
    task automatic ack(input logic [31:0] rd);
        mem_ack   = 1'b1;
        mem_rdata = rd;
        tick();
        mem_ack   = 1'b0;
        mem_rdata = 32'h0;
    endtask

    initial begin
        rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'h0;
        req_addr = 32'h0; req_wdata = 32'h0; mem_ack = 1'b0; mem_rdata = 32'h0;
        tick(); tick();
        check("rst_req_ready", {31'h0, req_ready}, 32'h0);
        check("rst_rsp_valid", {31'h0, rsp_valid}, 32'h0);
        check("rst_mem_req",   {31'h0, mem_req}, 32'h0);
        check("rst_mem_addr",  mem_addr, 32'h0);
        check("rst_mem_wstrb", {28'h0, mem_wstrb}, 32'h0);
        check("rst_mem_wdata", mem_wdata, 32'h0);
        check("rst_rsp_rdata", rsp_rdata, 32'h0);
        rst = 1'b0;
        tick();
        check("post_rst_ready", {31'h0, req_ready}, 32'h1);

        // SW 0xDEADBEEF @0x100
        send(1'b1, 3'b010, 32'h100, 32'hDEADBEEF);
        check("sw_mem_req",   {31'h0, mem_req}, 32'h1);
        check("sw_mem_we",    {31'h0, mem_we}, 32'h1);
        check("sw_mem_addr",  mem_addr, 32'h100);
        check("sw_wstrb",     {28'h0, mem_wstrb}, 32'hF);
        check("sw_wdata",     mem_wdata, 32'hDEADBEEF);
        check("sw_busy",      {31'h0, req_ready}, 32'h0);
        ack(32'h0);
        check("sw_rsp_valid", {31'h0, rsp_valid}, 32'h1);
        check("sw_rsp_err",   {31'h0, rsp_err}, 32'h0);
        check("sw_rsp_rdata", rsp_rdata, 32'h0);
        check("sw_req_drop",  {31'h0, mem_req}, 32'h0);
        tick();
        check("sw_ready_t3",  {31'h0, req_ready}, 32'h1);
        check("sw_rsp_pulse", {31'h0, rsp_valid}, 32'h0);

        // LB / LBU @0x101 from word 0x000080FF
        send(1'b0, 3'b000, 32'h101, 32'h0);
        check("lb_mem_addr",  mem_addr, 32'h100);
        check("lb_mem_we",    {31'h0, mem_we}, 32'h0);
        check("lb_wstrb",     {28'h0, mem_wstrb}, 32'h0);
        ack(32'h000080FF);
        check("lb_rdata",     rsp_rdata, 32'hFFFFFF80);
        tick();
        send(1'b0, 3'b100, 32'h101, 32'h0);
        ack(32'h000080FF);
        check("lbu_rdata",    rsp_rdata, 32'h00000080);
        tick();

        // LH / LHU @0x102 from word 0x80010000
        send(1'b0, 3'b001, 32'h102, 32'h0);
        ack(32'h80010000);
        check("lh_rdata",     rsp_rdata, 32'hFFFF8001);
        tick();
        send(1'b0, 3'b101, 32'h102, 32'h0);
        ack(32'h80010000);
        check("lhu_rdata",    rsp_rdata, 32'h00008001);
        tick();

        // SH 0x1234 @0x102
        send(1'b1, 3'b001, 32'h102, 32'h00001234);
        check("sh_mem_addr",  mem_addr, 32'h100);
        check("sh_wstrb",     {28'h0, mem_wstrb}, 32'hC);
        check("sh_wdata",     mem_wdata, 32'h12340000);
        ack(32'h0);
        check("sh_rsp_err",   {31'h0, rsp_err}, 32'h0);
        tick();

        // LW @0x103
        send(1'b0, 3'b010, 32'h103, 32'h0);
`ifdef LSU_MISALIGNED_EN
        check("lwx_addr0",    mem_addr, 32'h100);
        ack(32'hAABBCCDD);
        check("lwx_req1",     {31'h0, mem_req}, 32'h1);
        check("lwx_addr1",    mem_addr, 32'h104);
        check("lwx_no_rsp",   {31'h0, rsp_valid}, 32'h0);
        ack(32'h11223344);
        check("lwx_rsp",      {31'h0, rsp_valid}, 32'h1);
        check("lwx_rdata",    rsp_rdata, 32'h223344AA);
        check("lwx_err",      {31'h0, rsp_err}, 32'h0);
`else
        check("lwx_err_valid", {31'h0, rsp_valid}, 32'h1);
        check("lwx_err",       {31'h0, rsp_err}, 32'h1);
        check("lwx_no_mem",    {31'h0, mem_req}, 32'h0);
`endif
        tick();

        // SW @0xFFFFFFFE
        send(1'b1, 3'b010, 32'hFFFFFFFE, 32'hA1B2C3D4);
`ifdef LSU_MISALIGNED_EN
        check("swx_addr0",    mem_addr, 32'hFFFFFFFC);
        check("swx_wstrb0",   {28'h0, mem_wstrb}, 32'hC);
        check("swx_wdata0",   mem_wdata, 32'hC3D40000);
        ack(32'h0);
        check("swx_addr1",    mem_addr, 32'h00000000);
        check("swx_wstrb1",   {28'h0, mem_wstrb}, 32'h3);
        check("swx_wdata1",   mem_wdata, 32'h0000A1B2);
        ack(32'h0);
        check("swx_rsp",      {31'h0, rsp_valid}, 32'h1);
        check("swx_err",      {31'h0, rsp_err}, 32'h0);
`else
        check("swx_err",      {31'h0, rsp_err}, 32'h1);
        check("swx_no_mem",   {31'h0, mem_req}, 32'h0);
`endif
        tick();

        // LW with a stalled ack, reset mid-wait
        send(1'b0, 3'b010, 32'h200, 32'h0);
        check("stall_req",    {31'h0, mem_req}, 32'h1);
        check("stall_addr",   mem_addr, 32'h200);
        tick(); tick();
        rst = 1'b1;
        tick();
        check("abort_mem_req", {31'h0, mem_req}, 32'h0);
        check("abort_no_rsp",  {31'h0, rsp_valid}, 32'h0);
        rst = 1'b0;
        tick();
        check("abort_ready",   {31'h0, req_ready}, 32'h1);
        check("abort_no_rsp2", {31'h0, rsp_valid}, 32'h0);

        // Illegal load funct3 011 and store funct3 100
        send(1'b0, 3'b011, 32'h100, 32'h0);
        check("ill_ld_valid", {31'h0, rsp_valid}, 32'h1);
        check("ill_ld_err",   {31'h0, rsp_err}, 32'h1);
        check("ill_ld_rdata", rsp_rdata, 32'h0);
        check("ill_ld_nomem", {31'h0, mem_req}, 32'h0);
        tick();
        check("ill_ld_ready", {31'h0, req_ready}, 32'h1);
        send(1'b1, 3'b100, 32'h100, 32'h55);
        check("ill_st_err",   {31'h0, rsp_err}, 32'h1);
        check("ill_st_nomem", {31'h0, mem_req}, 32'h0);
        tick();
        check("idle_err_low", {31'h0, rsp_err}, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Processor-side initiator for the data memory port: accepts load/store requests from the execute stage, performs byte-lane alignment, generates write strobes and runs a request/acknowledge handshake toward data memory. Returns sign- or zero-extended load data to writeback. Sits between the ALU/register-file outputs (address, store data) and the data memory.

## Interface
- DWIDTH, 32, data and address width; only 32 is supported.
- clk  in  1  clock; all state changes on rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  1  execute stage presents a request.
- req_ready  out  1  unit can accept a request this cycle.
- req_we  in  1  1 = store, 0 = load.
- req_funct3  in  3  RISC-V funct3. Loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU. Stores: 000 SB, 001 SH, 010 SW.
- req_addr  in  DWIDTH  byte address (ALU result).
- req_wdata  in  DWIDTH  store data, right-justified.
- rsp_valid  out  1  one-cycle pulse: access finished.
- rsp_rdata  out  DWIDTH  extended load data; 0 for stores and errors.
- rsp_err  out  1  with rsp_valid: illegal funct3 or unsupported misalignment.
- mem_req  out  1  memory access request; held until mem_ack.
- mem_we  out  1  write enable for the current access.
- mem_addr  out  DWIDTH  word-aligned address; bits [1:0] always 0.
- mem_wstrb  out  4  byte-lane write strobes; 0 for reads.
- mem_wdata  out  DWIDTH  lane-shifted write data.
- mem_ack  in  1  memory completes the current access in this cycle. For a read, mem_rdata is valid in this cycle.
- mem_rdata  in  DWIDTH  read word.

## Operation
- States: IDLE, ACC0, ACC1, RESP.
- IDLE: req_ready=1. On req_valid, latch the request and decode it.
  - Illegal funct3 (load 011/110/111; store with funct3[2]=1), or misalignment with the macro off: go to RESP with rsp_err=1. No memory access is made.
  - Otherwise go to ACC0.
- Misaligned: halfword with addr[0]=1, or word with addr[1:0]!=0.
- Crossing: byte offset + size > 4.
- ACC0: mem_req=1, mem_addr={addr[31:2],2'b00}. Signals are held stable until mem_ack.
  - On mem_ack, go to ACC1 if the access crosses a word boundary, else go to RESP.
- ACC1: mem_addr = first word address + 4, modulo 2^32 (0xFFFFFFFC wraps to 0x00000000). On mem_ack, go to RESP.
- RESP: rsp_valid=1 for one cycle, then go to IDLE.
- Little-endian lane rules, with off=addr[1:0] and mask = 0x1/0x3/0xF for B/H/W:
  - Store: 8-bit strobe = mask<<off. 64-bit data = wdata<<(8*off). ACC0 uses the low nibble and low word; ACC1 uses the high nibble and high word.
  - Load: 64-bit {rdata_ACC1, rdata_ACC0} >> (8*off). Take the low 8/16/32 bits, then sign-extend (LB/LH) or zero-extend (LBU/LHU).
- reset: forces IDLE. Any in-flight access is abandoned and no response is issued; the memory side must tolerate mem_req dropping.

## Timing
- Reset values: req_ready=0 while rst=1, 1 from the first cycle after. rsp_valid, rsp_err, rsp_rdata, mem_req, mem_we, mem_addr, mem_wstrb, mem_wdata all 0.
- All outputs are registered or decoded from state only. There are no combinational paths from req_* or mem_ack to outputs.
- Request accepted in cycle T. mem_req rises at T+1.
- With mem_ack in that same cycle, rsp_valid is at T+2 and req_ready returns at T+3.
- A crossing access adds 1 cycle plus the memory wait for its second access.
- Error response: rsp_valid at T+1.
- Only one request is outstanding at a time. req_valid while req_ready=0 is ignored; the requester holds it.

## Configuration
- LSU_MISALIGNED_EN:
  - Defined: misaligned accesses are performed. An access inside one word uses one access; a crossing access is split into two.
  - Undefined: any misaligned access returns rsp_err=1 with no memory traffic, and ACC1 is unreachable.

## Test plan
- SW 0xDEADBEEF @0x100, mem_ack same cycle: mem_addr 0x100, wstrb 0xF, wdata 0xDEADBEEF; rsp_valid at T+2, err 0.
- LB @0x101, memory word 0x0000_80FF at 0x100: rsp_rdata 0xFFFFFF80. LBU from the same address: 0x00000080.
- SH 0x1234 @0x102: wstrb 0xC, wdata 0x12340000.
- LW @0x103 (macro on), words 0x100=0xAABBCCDD and 0x104=0x11223344: two accesses (0x100, then 0x104); rsp_rdata 0x223344AA. With the macro off: rsp_err=1, mem_req never asserted.
- SW @0xFFFFFFFE (macro on): second access at 0x00000000 with wstrb 0x3.
- LW with mem_ack delayed 3 cycles, rst asserted mid-wait: next cycle mem_req=0, req_ready=1 after reset, no rsp_valid. Load funct3 011: rsp_err=1 at T+1.
